// File: rtl/avg_pkg.sv
// +--------------------------------------------------------------------------+
// | avg_pkg : shared constants and types for the eight-input averager.        |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package avg_pkg;
  localparam int         AVG_TAPS = 8;
  localparam logic [7:0] AVG_SA   = 8'd1;
  localparam int         FILL_W   = 4;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;
endpackage

`default_nettype wire

// File: rtl/avg_window_collector.sv
// +--------------------------------------------------------------------------+
// | avg_window_collector : assembles 8-sample windows for the averager.       |
// | Tumbling windows by default; AVG_WINDOW_SLIDE_EN selects sliding windows. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module avg_window_collector
  import avg_pkg::*;
#(
  parameter int DATAWIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 flush,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATAWIDTH-1:0] a,
  output logic [DATAWIDTH-1:0] b,
  output logic [DATAWIDTH-1:0] c,
  output logic [DATAWIDTH-1:0] d,
  output logic [DATAWIDTH-1:0] e,
  output logic [DATAWIDTH-1:0] f,
  output logic [DATAWIDTH-1:0] g,
  output logic [DATAWIDTH-1:0] h,
  output logic [7:0]           sa,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic [FILL_W-1:0]    fill_cnt
);

  logic [DATAWIDTH-1:0] r_slot [AVG_TAPS];
  logic [FILL_W-1:0]    r_fill;

  assign a        = r_slot[0];
  assign b        = r_slot[1];
  assign c        = r_slot[2];
  assign d        = r_slot[3];
  assign e        = r_slot[4];
  assign f        = r_slot[5];
  assign g        = r_slot[6];
  assign h        = r_slot[7];
  assign sa       = AVG_SA;
  assign fill_cnt = r_fill;

`ifdef AVG_WINDOW_SLIDE_EN
  logic r_win_valid;
  logic w_accept;

  assign win_valid = r_win_valid;
  // A take frees the window this cycle, so the next sample can replace it.
  assign in_ready  = !r_win_valid || win_ready;
  assign w_accept  = in_valid && in_ready;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < AVG_TAPS; i++) r_slot[i] <= '0;
      r_fill      <= '0;
      r_win_valid <= 1'b0;
    end else if (flush) begin
      r_fill      <= '0;
      r_win_valid <= 1'b0;
    end else if (w_accept) begin
      for (int i = 0; i < AVG_TAPS - 1; i++) r_slot[i] <= r_slot[i+1];
      r_slot[AVG_TAPS-1] <= in_data;
      if (r_fill >= FILL_W'(AVG_TAPS - 1)) begin
        r_fill      <= FILL_W'(AVG_TAPS);
        r_win_valid <= 1'b1;
      end else begin
        r_fill <= r_fill + 1'b1;
      end
    end else if (r_win_valid && win_ready) begin
      r_win_valid <= 1'b0;
    end
  end
`else
  state_t r_state;

  assign in_ready  = (r_state == FILL);
  assign win_valid = (r_state == FULL);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < AVG_TAPS; i++) r_slot[i] <= '0;
      r_fill  <= '0;
      r_state <= FILL;
    end else if (flush) begin
      r_fill  <= '0;
      r_state <= FILL;
    end else begin
      case (r_state)
        FILL: begin
          if (in_valid) begin
            r_slot[r_fill[2:0]] <= in_data;
            r_fill              <= r_fill + 1'b1;
            if (r_fill == FILL_W'(AVG_TAPS - 1)) r_state <= FULL;
          end
        end
        FULL: begin
          // Slots keep their old contents; only the count restarts.
          if (win_ready) begin
            r_fill  <= '0;
            r_state <= FILL;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_avg_window_collector.sv
// +--------------------------------------------------------------------------+
// | tb_avg_window_collector : self-checking bench, queue model + directed.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_avg_window_collector;
  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a, b, c, d, e, f, g, h;
  logic [7:0]  sa;
  logic        win_valid;
  logic        win_ready = 1'b0;
  logic [3:0]  fill_cnt;

  int nchk = 0;
  int nerr = 0;

  avg_window_collector #(.DATAWIDTH(16)) dut (
    .Clk(Clk), .Rst(Rst), .flush(flush), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .sa(sa), .win_valid(win_valid), .win_ready(win_ready), .fill_cnt(fill_cnt)
  );

  always #5 Clk = ~Clk;

`ifdef AVG_WINDOW_SLIDE_EN
  localparam bit SLIDE = 1'b1;
`else
  localparam bit SLIDE = 1'b0;
`endif

  // Reference: the samples of the current window in arrival order.
  logic [15:0] mq[$];
  bit          mv = 1'b0;

  function automatic bit m_in_ready();
    return SLIDE ? (!mv || win_ready) : !mv;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : model
    bit acc, take;
    forever begin
      @(posedge Clk);
      if (!Rst) begin
        mq.delete();
        mv = 1'b0;
      end else begin
        acc  = in_valid && m_in_ready();
        take = mv && win_ready;
        if (flush) begin
          mq.delete();
          mv = 1'b0;
        end else if (SLIDE) begin
          if (acc) begin
            mq.push_back(in_data);
            if (mq.size() > 8) void'(mq.pop_front());
            if (mq.size() == 8) mv = 1'b1;
          end else if (take) begin
            mv = 1'b0;
          end
        end else begin
          if (take) begin
            mq.delete();
            mv = 1'b0;
          end else if (acc) begin
            mq.push_back(in_data);
            if (mq.size() == 8) mv = 1'b1;
          end
        end
      end
    end
  end

  initial begin : compare
    logic [15:0] w [8];
    forever begin
      @(negedge Clk);
      w = '{a, b, c, d, e, f, g, h};
      chk("m_win_valid", {31'd0, win_valid}, {31'd0, mv});
      chk("m_in_ready", {31'd0, in_ready}, {31'd0, m_in_ready()});
      chk("m_fill_cnt", {28'd0, fill_cnt}, mq.size());
      chk("m_sa", {24'd0, sa}, 32'd1);
      if (mv && mq.size() == 8)
        for (int i = 0; i < 8; i++) chk("m_slot", {16'd0, w[i]}, {16'd0, mq[i]});
    end
  end

  task automatic cyc();
    @(negedge Clk);
    #2;
  endtask

  task automatic push(input logic [15:0] v);
    in_valid = 1'b1;
    in_data  = v;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic chk_win(input string name, input int first);
    logic [15:0] w [8];
    w = '{a, b, c, d, e, f, g, h};
    for (int i = 0; i < 8; i++) chk(name, {16'd0, w[i]}, first + i);
  endtask

  initial begin : stim
    #3;
    chk("rst_win_valid", {31'd0, win_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_fill", {28'd0, fill_cnt}, 32'd0);
    chk("rst_a", {16'd0, a}, 32'd0);
    cyc();
    Rst = 1'b1;
    cyc();

`ifndef AVG_WINDOW_SLIDE_EN
    // Back-to-back 1..8 with ready downstream.
    win_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = 16'(i);
      cyc();
    end
    in_valid = 1'b0;
    chk("t1_valid", {31'd0, win_valid}, 32'd1);
    chk("t1_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t1_sa", {24'd0, sa}, 32'd1);
    chk_win("t1_win", 1);
    cyc();
    chk("t1_valid_drop", {31'd0, win_valid}, 32'd0);
    chk("t1_ready_back", {31'd0, in_ready}, 32'd1);

    // Long hold with all-ones samples.
    win_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(16'hFFFF);
    for (int i = 0; i < 20; i++) begin
      chk("t2_hold_valid", {31'd0, win_valid}, 32'd1);
      chk("t2_hold_ready", {31'd0, in_ready}, 32'd0);
      chk("t2_hold_h", {16'd0, h}, 32'hFFFF);
      in_valid = 1'b1;
      in_data  = 16'h1234;
      cyc();
    end
    in_valid  = 1'b0;
    chk("t2_a", {16'd0, a}, 32'hFFFF);
    win_ready = 1'b1;
    cyc();
    chk("t2_fill0", {28'd0, fill_cnt}, 32'd0);

    // Flush with a simultaneous sample.
    for (int i = 0; i < 5; i++) push(16'(100 + i));
    chk("t3_fill5", {28'd0, fill_cnt}, 32'd5);
    flush = 1'b1;
    push(16'd99);
    flush = 1'b0;
    chk("t3_fill0", {28'd0, fill_cnt}, 32'd0);
    win_ready = 1'b0;
    for (int i = 10; i <= 17; i++) push(16'(i));
    chk_win("t3_win", 10);

    // Asynchronous reset while holding a full window.
    #1;
    Rst = 1'b0;
    #1;
    chk("t4_valid", {31'd0, win_valid}, 32'd0);
    chk("t4_fill", {28'd0, fill_cnt}, 32'd0);
    chk("t4_ready", {31'd0, in_ready}, 32'd1);
    chk("t4_a", {16'd0, a}, 32'd0);
    cyc();
    cyc();
    Rst = 1'b1;
    cyc();
`else
    // Sliding: 1..10 gives windows 1..8, 2..9, 3..10.
    win_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_data = 16'(i);
      cyc();
      if (i >= 8) begin
        chk("s1_valid", {31'd0, win_valid}, 32'd1);
        chk_win("s1_win", i - 7);
      end
    end
    in_valid = 1'b0;
    cyc();
    chk("s1_valid_drop", {31'd0, win_valid}, 32'd0);
    chk("s1_fill", {28'd0, fill_cnt}, 32'd8);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("s2_fill0", {28'd0, fill_cnt}, 32'd0);
    for (int i = 0; i < 7; i++) push(16'(50 + i));
    chk("s2_not_primed", {31'd0, win_valid}, 32'd0);
    push(16'd57);
    chk_win("s2_win", 50);
`endif

    // Random stalls; the per-cycle compare guards ordering and contents.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      win_ready = ($urandom_range(0, 2) == 0);
      flush     = ($urandom_range(0, 59) == 0);
      in_data   = 16'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/avg_window_collector.md
# avg_window_collector

Streaming front end for the eight-input averager. It accepts 16-bit samples one per handshake on a valid/ready input and assembles them into an eight-sample window. It presents the window as parallel words `a`..`h`, plus the per-stage shift amount `sa`, and holds them until the averager side accepts. By default windows are tumbling (disjoint groups of eight). A build-time option switches to a sliding window with one new window per accepted sample.

## Interface
- `DATAWIDTH`, 16, sample width; must match the averager's input width.
- `Clk`  in  1  rising-edge clock.
- `Rst`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous; discards the partial window.
- `in_data`  in  DATAWIDTH  sample.
- `in_valid`  in  1  sample present.
- `in_ready`  out  1  collector can accept the sample this cycle.
- `a`,`b`,`c`,`d`,`e`,`f`,`g`,`h`  out  DATAWIDTH each  window slots; `a` is oldest, `h` is newest.
- `sa`  out  8  shift amount, constant 8'd1 (three shift stages divide by 8).
- `win_valid`  out  1  window on `a`..`h` is complete and stable.
- `win_ready`  in  1  downstream takes the window.
- `fill_cnt`  out  4  samples currently held, 0..8.

## Operation
- A sample is accepted when `in_valid && in_ready`. A window is taken when `win_valid && win_ready`.
- Tumbling mode uses two states:
  - FILL: `in_ready`=1 and `win_valid`=0. Each accepted sample is written to slot index `fill_cnt` (0→`a` … 7→`h`), then `fill_cnt` increments. Accepting the sample at `fill_cnt`==7 sets `fill_cnt`=8 and moves to FULL.
  - FULL: `in_ready`=0 and `win_valid`=1. Slots are frozen. On window take, return to FILL with `fill_cnt`=0. Slot contents are not cleared.
- `flush` sets `fill_cnt`=0 and the state to FILL, and deasserts `win_valid`. It overrides a simultaneous sample accept (the sample is dropped) and a simultaneous window take (the take still counts downstream; the collector does not care).
- `in_valid` low in FILL leaves all registers unchanged. A window is never emitted with fewer than eight samples.
- Downstream may hold `win_ready` low indefinitely. `a`..`h` must not change while `win_valid`=1 and the window is not taken.
- Arithmetic: no arithmetic on sample data. `fill_cnt` never exceeds 8 and never wraps.

## Timing
- Reset values: every slot is 0, `fill_cnt`=0, state FILL, `in_ready`=1, `win_valid`=0. `sa`=1 always.
- `in_ready` and `win_valid` are decoded from registered state only. There is no combinational path from `in_valid` or `win_ready`.
- Latency: `win_valid` rises on the clock edge that accepts the eighth sample, so it is visible in the following cycle.
- Tumbling throughput: at most 8 samples per 9 cycles. `in_ready` returns in the cycle after the take.
- Reset asserted mid-window or mid-hold returns all state to reset values immediately, with no emission.

## Configuration
- `AVG_WINDOW_SLIDE_EN` undefined: tumbling behaviour as described above.
- `AVG_WINDOW_SLIDE_EN` defined: the slots form a shift register.
  - On each accepted sample, `a`←`b` … `g`←`h`, `h`←`in_data`. `fill_cnt` saturates at 8.
  - `in_ready` = !`win_valid` || `win_ready`.
  - `win_valid` is set on any accept that leaves `fill_cnt`==8. It is cleared on a take without a simultaneous accept. It stays 1 on a simultaneous take and accept, presenting the new window.
  - Once primed, full throughput is one window per accepted sample.
  - `flush` clears `fill_cnt` and `win_valid` only. After a flush, the window must be re-primed with eight samples.

## Structure
- Shared package (`avg_pkg`):
  - `AVG_TAPS`=8
  - `AVG_SA`=8'd1
  - fill-count width 4
  - state typedef {FILL, FULL}
- Single module. The eight slots are a register array indexed by `fill_cnt` in tumbling mode and chained in sliding mode. No sub-module.

## Test plan
- Reset, then push 1..8 back-to-back with `win_ready`=1 → `win_valid` is high for one cycle with a..h=1..8 and `sa`=1; `in_ready` is low that cycle and high the next.
- Push 8 samples of 16'hFFFF with `win_ready` held low for 20 cycles → window is stable and `in_ready`=0 throughout; take on release, `fill_cnt`→0.
- Push 5 samples, assert `flush` together with a sixth valid sample → `fill_cnt`=0; the next 8 samples 10..17 appear as a..h=10..17.
- Assert `Rst` low while holding a full window → `win_valid`=0, `fill_cnt`=0, `in_ready`=1 asynchronously.
- Sliding build: push 1..10 with `win_ready`=1 → windows {1..8}, {2..9}, {3..10} on consecutive accepts.
- Random `in_valid`/`win_ready` stall patterns in both builds against a reference queue model → no lost, duplicated or reordered samples.
